// File: rtl/mp_add_seq.sv
// Multi-precision adder/subtractor: one DATA_WIDTH word per cycle, LSW first,
// with a registered carry chain between words and valid/ready on both sides.
module mp_add_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_sub,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  in_a,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  in_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  out_result,
  output logic                             out_carry,
  output logic                             busy
);

  localparam int unsigned W     = DATA_WIDTH * NUM_WORDS;
  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        result_d;
  logic                out_carry_d;
  logic                out_valid_d;
  logic [31:0]         word_base;
  logic [SUM_W-1:0]    sum_c;
  logic                last_word;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == RUN) || (state_q == DONE);

  // Single word adder; B is already inverted for subtraction.
  assign word_base = 32'(idx_q) * DATA_WIDTH;
  assign sum_c     = {1'b0, a_q[word_base +: DATA_WIDTH]}
                   + {1'b0, b_q[word_base +: DATA_WIDTH]}
                   + SUM_W'(carry_q);
  assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      out_result <= result_d;
      out_carry  <= out_carry_d;
      out_valid  <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = out_result;
    out_carry_d = out_carry;
    out_valid_d = out_valid;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_sub ? ~in_b : in_b;
          carry_d  = in_sub;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[word_base +: DATA_WIDTH] = sum_c[DATA_WIDTH-1:0];
        carry_d = sum_c[DATA_WIDTH];
        if (last_word) begin
          out_carry_d = sum_c[DATA_WIDTH];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq: vector table plus backpressure and reset sequences.
module tb_mp_add_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 4;
  localparam int unsigned W  = DW * NW;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_res;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  mp_add_seq #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .busy(busy)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] res, output logic c, output int lat);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~sub;
    check("run_busy", W'(busy), W'(1));
    check("run_in_ready", W'(in_ready), W'(0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    c   = out_carry;
  endtask

  initial begin
    logic [W-1:0] res;
    logic         c;
    int           lat;
    logic [W-1:0] ones;
    ones = '1;

    vecs[0] = '{128'h00000000_00000000_00000000_FFFFFFFF, 128'h1, 1'b0,
                128'h00000000_00000000_00000001_00000000, 1'b0};
    vecs[1] = '{ones, 128'h1, 1'b0, 128'h0, 1'b1};
    vecs[2] = '{128'h5, 128'h7, 1'b1, ones - 128'h1, 1'b0};
    vecs[3] = '{128'h7, 128'h5, 1'b1, 128'h2, 1'b1};
    vecs[4] = '{128'h0, 128'h0, 1'b0, 128'h0, 1'b0};
    vecs[5] = '{ones, ones, 1'b0, ones - 128'h1, 1'b1};
    vecs[6] = '{128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                1'b1, 128'h0, 1'b1};
    vecs[7] = '{128'h0, 128'h1, 1'b1, ones, 1'b0};
    vecs[8] = '{128'h00000001_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0,
                128'h00000002_00000000_00000000_00000000, 1'b0};
    vecs[9] = '{128'h11111111_22222222_33333333_44444444, 128'h01010101_02020202_03030303_04040404,
                1'b0, 128'h12121212_24242424_36363636_48484848, 1'b0};

    resetn = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_result", out_result, '0);
    check("rst_out_carry", W'(out_carry), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_busy", W'(busy), W'(0));

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, res, c, lat);
      check($sformatf("vec%0d_latency", i), W'(lat), W'(NW));
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_carry", i), W'(c), W'(vecs[i].exp_carry));
      @(negedge clk);
      check($sformatf("vec%0d_handshake", i), W'(out_valid), W'(0));
      check($sformatf("vec%0d_idle", i), W'(in_ready), W'(1));
      check($sformatf("vec%0d_hold_result", i), out_result, vecs[i].exp_res);
    end

    // Backpressure: result held, stray request ignored.
    out_ready = 1'b0;
    run_op(128'd10, 128'd20, 1'b0, res, c, lat);
    check("bp_latency", W'(lat), W'(NW));
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_out_result", out_result, 128'd30);
      check("bp_in_ready", W'(in_ready), W'(0));
      if (i == 3) begin in_valid = 1'b1; in_a = 128'd99; in_b = 128'd1; in_sub = 1'b0; end
      if (i == 4) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", W'(out_valid), W'(0));
    check("bp_release_ready", W'(in_ready), W'(1));
    check("bp_release_result", out_result, 128'd30);
    @(negedge clk);
    check("bp_stray_ignored", W'(busy), W'(0));

    // Leave out_carry=1 so the mid-operation reset has something to clear.
    run_op(128'd7, 128'd5, 1'b1, res, c, lat);
    check("pre_rst_carry", W'(c), W'(1));
    @(negedge clk);

    in_valid = 1'b1; in_a = 128'd5; in_b = 128'd7; in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("mid_rst_out_valid", W'(out_valid), W'(0));
    check("mid_rst_out_result", out_result, '0);
    check("mid_rst_out_carry", W'(out_carry), W'(0));
    check("mid_rst_in_ready", W'(in_ready), W'(1));
    check("mid_rst_busy", W'(busy), W'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_result", W'(out_valid), W'(0));
    end
    run_op(128'd3, 128'd4, 1'b0, res, c, lat);
    check("post_rst_latency", W'(lat), W'(NW));
    check("post_rst_result", res, 128'd7);
    check("post_rst_carry", W'(c), W'(0));
    @(negedge clk);
    check("post_rst_idle", W'(in_ready), W'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
Multi-precision adder/subtractor sequencer. It accepts two NUM_WORDS*DATA_WIDTH-bit operands over a valid/ready handshake and processes them one DATA_WIDTH-bit word per cycle, LSW first, through a single word adder with a registered carry chain. It presents the full-width result and final carry over a second valid/ready handshake. It sits in front of the GF/integer arithmetic units wherever operands are wider than one adder word.

Parameters:
DATA_WIDTH, 32, width of one adder word
NUM_WORDS, 4, number of words per operand (>=2); full operand width W = DATA_WIDTH*NUM_WORDS

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  reset, synchronous, active-low
in_valid  input  1  operand request valid
in_ready  output  1  block can accept a request
in_sub  input  1  0 = A+B, 1 = A-B (A + ~B + 1)
in_a  input  W  operand A
in_b  input  W  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  W  sum/difference, modulo 2^W
out_carry  output  1  final carry out (for sub: 1 = no borrow, A>=B unsigned)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE; out_valid=0, out_result=0, out_carry=0, busy=0; word index and internal carry cleared. Reset wins over any handshake in the same cycle and aborts any operation in progress without producing a result.
- in_ready = (state==IDLE), combinational from state only. It does not depend on in_valid.
- FSM states:
  - IDLE: on in_valid&in_ready, latch in_a, in_b (inverted if in_sub), carry := in_sub, idx := 0, clear result register, then go to RUN.
  - RUN: each cycle compute {c,s} = A[idx] + B'[idx] + carry, with width DATA_WIDTH+1. Write s into result word idx, set carry := c, then idx++. When idx==NUM_WORDS-1, write the last word and go to DONE with out_valid=1, out_carry=c.
  - DONE: hold out_valid, out_result and out_carry stable until out_valid&out_ready, then go to IDLE with out_valid=0. out_result and out_carry keep their last values after the handshake.
- Latency: the accept edge is E0. out_valid rises after edge E0+NUM_WORDS. Throughput is one operation per NUM_WORDS+2 cycles at best, because a new request cannot be accepted in the same cycle that a result is accepted.
- in_valid/in_a/in_b/in_sub are ignored outside IDLE, and operands are sampled only at the accept edge. Later changes to the inputs do not affect the operation in flight.
- out_ready may be held high permanently; DONE then lasts exactly one cycle.
- Carry chains across word boundaries: word k uses the carry-out of word k-1, and word 0 uses in_sub as its carry-in.
- Wrap-around: the result is modulo 2^W. Overflow is reported only via out_carry; there is no separate overflow flag.
- idx counter width is clog2(NUM_WORDS). The FSM never lets idx exceed NUM_WORDS-1.

Test Plan:
1. Reset, then idle: out_valid=0, out_result=0, out_carry=0, in_ready=1, busy=0.
2. Carry propagation: A=0x00000000_00000000_00000000_FFFFFFFF, B=1, sub=0, out_ready=1 -> out_valid asserted 4 cycles after accept, result=0x00000000_00000000_00000001_00000000, carry=0.
3. Full-width carry: A=all ones, B=1, sub=0 -> result=0, carry=1.
4. Subtract: A=5, B=7, sub=1 -> result=2^128-2 (0xFFFF...FFFE), carry=0. Then A=7, B=5 -> result=2, carry=1.
5. Backpressure: out_ready=0 for 10 cycles after out_valid. Check out_valid/out_result stable, in_ready=0, and an in_valid pulse with new operands is ignored. Raise out_ready -> one-cycle handshake, then IDLE, in_ready=1.
6. Mid-operation reset: resetn=0 for one cycle 2 cycles after accept -> next cycle IDLE, out_valid=0, outputs 0. A following request A=3, B=4 completes correctly with result=7, carry=0.
